ksa_rr_sched: RTL and testbench
===============================

// Module: ksa_rr_sched
// PURPOSE
//  Shares a single WIDTH-bit Kogge-Stone adder (KSA_2) between NREQ requesters in the DPE CSA datapath.
//  Arbitration is round-robin and each request uses a valid/ready handshake.
//  Operands are registered in front of the adder and the sum is registered behind it:
//  issue rate is 1 add/cycle, latency is 2 cycles.
//  The result is returned on a shared bus, tagged by a one-hot rsp_valid.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (DPE_params.sv value); passed to KSA_2
//  NREQ   4  number of requesters, >=2; ID_W = $clog2(NREQ)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   NREQ        per-requester request valid
//  req_ready  out  NREQ        per-requester grant; at most one bit set
//  req_a      in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand b, same packing
//  req_cin    in   NREQ        carry-in, requester i at bit i
//  rsp_valid  out  NREQ        one-hot, 1-cycle pulse: result for requester i
//  rsp_sum    out  WIDTH       registered sum
//  rsp_cout   out  1           registered carry-out
//  busy       out  1           op stage or rsp stage holds a valid entry
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - rr_ptr=0; op_vld=0; rsp_valid=0; rsp_sum=0; rsp_cout=0.
//   - In-flight ops are dropped: no rsp_valid for them, ever.
//   - req_ready=0 while rst=1.
//  Arbiter (combinational from req_valid and rr_ptr):
//   - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[grant]=1 only. If no valid, req_ready=0.
//   - req_ready never depends on the response side; there is no backpressure.
//   - Transfer occurs when req_valid[i] & req_ready[i] at an edge.
//   - Requester must hold valid, a, b, cin stable until it sees ready.
//   - Requester may drop valid without a grant (no penalty).
//  rr_ptr: on each transfer by requester g, rr_ptr <= (g+1) mod NREQ. Unchanged when idle.
//  Stage 1 (edge T, transfer):
//   - op_a, op_b, op_cin <= granted operands; op_id <= g; op_vld <= 1.
//   - With no transfer: op_vld <= 0.
//  Stage 2 (edge T+1):
//   - KSA_2 computes from the op_* registers.
//   - If op_vld: {rsp_cout, rsp_sum} <= op_a + op_b + op_cin (WIDTH+1 bits, exact);
//     rsp_valid <= (1<<op_id).
//   - Else rsp_valid <= 0; rsp_sum/rsp_cout hold their last value.
//  Latency: result is visible in the cycle after edge T+1 (2 edges after transfer).
//  Back-to-back: a new transfer every cycle is legal; results come out in grant order.
//  busy = op_vld | (|rsp_valid).
//  Fairness: with NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
//  A lone continuously-valid requester is granted every cycle.
// TESTING
//  1. Reset, then req_valid[0]=1, a=0xAA, b=0x24, cin=0 (others idle)
//     -> ready[0] in the same cycle; rsp_valid=4'b0001, sum=0xCE, cout=0, 2 edges later.
//  2. Requester 2: a=0xFF, b=0x01, cin=1 -> rsp_valid=4'b0100, sum=0x01, cout=1.
//  3. All 4 valid continuously from reset for 8 cycles
//     -> grant order 0,1,2,3,0,1,2,3; one rsp_valid per cycle in the same order.
//  4. Only req 3 valid for 5 cycles, a=i, b=2*i -> 5 consecutive grants, sums 3*i in order.
//  5. rst=1 the edge after a transfer -> no rsp_valid afterwards; rr_ptr=0; busy=0.
//  6. Random a/b/cin on all requesters for 200 transfers
//     -> every {cout,sum} == a+b+cin; at most one req_ready bit set and one rsp_valid bit set.

Source files
------------

// File: rtl/ksa_rr_sched.sv
// Round-robin scheduler sharing one Kogge-Stone adder among NREQ requesters.
// Operands and sum are registered: one add per cycle, two-edge latency.
module ksa_2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);
   localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [LV:0][WIDTH-1:0] gg;
   logic [LV:0][WIDTH-1:0] pp;
   logic [WIDTH-1:0]       c;

   assign gg[0] = a_i & b_i;
   assign pp[0] = a_i ^ b_i;

   // Prefix tree: level l combines spans 2**l apart
   for (genvar l = 0; l < LV; l++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << l)) begin : g_op
            assign gg[l+1][i] = gg[l][i]
                              | (pp[l][i] & gg[l][i-(1<<l)]);
            assign pp[l+1][i] = pp[l][i] & pp[l][i-(1<<l)];
         end else begin : g_pass
            assign gg[l+1][i] = gg[l][i];
            assign pp[l+1][i] = pp[l][i];
         end
      end
   end

   assign c[0] = cin_i;
   for (genvar i = 1; i < WIDTH; i++) begin : g_c
      assign c[i] = gg[LV][i-1] | (pp[LV][i-1] & cin_i);
   end

   assign sum_o  = pp[0] ^ c;
   assign cout_o = gg[LV][WIDTH-1] | (pp[LV][WIDTH-1] & cin_i);
endmodule

module ksa_rr_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  busy
);
   localparam int ID_W = $clog2(NREQ);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_vld;
   logic             xfer;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic             op_cin_q;
   logic [ID_W-1:0]  op_id_q;
   logic             op_vld_q;
   logic [NREQ-1:0]  rsp_valid_q;
   logic [WIDTH-1:0] rsp_sum_q, sum_d;
   logic             rsp_cout_q, cout_d;

   // Walk offsets downward so the nearest valid one from rr_ptr wins
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx[ID_W-1:0];
         end
      end
   end

   assign xfer      = gnt_vld & ~rst;
   assign req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
   assign rr_ptr_d  = (gnt_id == ID_W'(NREQ - 1)) ? '0
                                                   : gnt_id + 1'b1;

   ksa_2 #(.WIDTH(WIDTH)) u_ksa (
      .a_i    (op_a_q),
      .b_i    (op_b_q),
      .cin_i  (op_cin_q),
      .sum_o  (sum_d),
      .cout_o (cout_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         op_vld_q    <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_cin_q    <= 1'b0;
         op_id_q     <= '0;
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         op_vld_q <= xfer;
         if (xfer) begin
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= req_a[gnt_id*WIDTH +: WIDTH];
            op_b_q   <= req_b[gnt_id*WIDTH +: WIDTH];
            op_cin_q <= req_cin[gnt_id];
            op_id_q  <= gnt_id;
         end
         if (op_vld_q) begin
            rsp_valid_q <= NREQ'(1) << op_id_q;
            rsp_sum_q   <= sum_d;
            rsp_cout_q  <= cout_d;
         end else begin
            rsp_valid_q <= '0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign busy      = op_vld_q | (|rsp_valid_q);
endmodule

// File: tb/tb_ksa_rr_sched.sv
// Scoreboard bench for ksa_rr_sched: driver queues expected sums,
// monitor pops and compares whenever rsp_valid is raised.
module tb_ksa_rr_sched;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic [NREQ-1:0]       req_cin = '0;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  busy;

   typedef struct {
      int         id;
      logic [7:0] sum;
      logic       cout;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   ksa_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] s,
                       input logic c);
      exp_t e;
      e.id = id;
      e.sum = s;
      e.cout = c;
      q.push_back(e);
   endtask

   task automatic set_op(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_cin[i] = c;
   endtask

   // Called just after a falling edge with inputs already set
   task automatic tick(input logic [NREQ-1:0] exp_rdy, input bit exact,
                       input bit auto_push);
      logic [8:0] s;
      #1;
      if (exact) begin
         chk("ready", 32'(req_ready), 32'(exp_rdy));
      end else begin
         chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         chk("ready_in_valid", 32'(req_ready & ~req_valid), 32'd0);
      end
      if (auto_push && !rst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               s = {1'b0, req_a[i*WIDTH +: WIDTH]}
                 + {1'b0, req_b[i*WIDTH +: WIDTH]}
                 + {8'd0, req_cin[i]};
               push(i, s[7:0], s[8]);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int k = 0; k < n; k++) tick('0, 1'b1, 1'b0);
   endtask

   always @(negedge clk) begin
      if (|rsp_valid) begin
         exp_t e;
         chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
         if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = q.pop_front();
            chk("rsp_id", 32'(rsp_valid), 32'(1 << e.id));
            chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
            chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
         end
      end
   end

   initial begin
      int n;
      int cyc;
      @(negedge clk);
      // Reset: ready held low even with requests pending
      rst = 1'b1;
      req_valid = 4'b1111;
      tick('0, 1'b1, 1'b0);
      tick('0, 1'b1, 1'b0);
      req_valid = '0;
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_sum", 32'(rsp_sum), 32'd0);
      chk("rst_cout", 32'(rsp_cout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);

      // Test 1
      set_op(0, 8'hAA, 8'h24, 1'b0);
      req_valid = 4'b0001;
      push(0, 8'hCE, 1'b0);
      tick(4'b0001, 1'b1, 1'b0);
      idle(3);

      // Test 2 (rr_ptr now 1)
      set_op(2, 8'hFF, 8'h01, 1'b1);
      req_valid = 4'b0100;
      push(2, 8'h01, 1'b1);
      tick(4'b0100, 1'b1, 1'b0);
      idle(3);

      // Test 3: all valid from reset
      for (int i = 0; i < NREQ; i++)
         set_op(i, 8'(8'h30 + i * 8'h11), 8'(8'h40 + i), 1'(i));
      rst = 1'b1;
      req_valid = 4'b1111;
      tick('0, 1'b1, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++)
         tick(4'(1 << (k % 4)), 1'b1, 1'b1);
      idle(3);

      // Test 4: lone requester 3
      req_valid = 4'b1000;
      for (int i = 1; i <= 5; i++) begin
         set_op(3, 8'(i), 8'(2 * i), 1'b0);
         push(3, 8'(3 * i), 1'b0);
         tick(4'b1000, 1'b1, 1'b0);
      end
      idle(3);

      // Test 5: reset right after a transfer drops it
      set_op(1, 8'h12, 8'h34, 1'b0);
      req_valid = 4'b0010;
      tick(4'b0010, 1'b1, 1'b0);
      rst = 1'b1;
      req_valid = '0;
      tick('0, 1'b1, 1'b0);
      rst = 1'b0;
      chk("rst5_busy", 32'(busy), 32'd0);
      chk("rst5_rsp_valid", 32'(rsp_valid), 32'd0);
      idle(3);
      req_valid = 4'b1111;
      tick(4'b0001, 1'b1, 1'b1);
      idle(3);

      // Test 6: random traffic
      n = 0;
      cyc = 0;
      while (n < 200 && cyc < 2000) begin
         for (int i = 0; i < NREQ; i++)
            set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
         req_valid = 4'($urandom_range(1, 15));
         if (cyc % 3 == 0) req_valid = 4'b1111;
         #1;
         if (|req_ready) n++;
         #0;
         tick('0, 1'b0, 1'b1);
         cyc++;
      end
      chk("rand_transfers", 32'(n), 32'd200);
      idle(5);
      chk("queue_drained", 32'(q.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
